dsp_sequencer: RTL and testbench

DSP_SEQUENCER -- requirements
Module: dsp_sequencer

---
 rtl/dsp_sequencer.sv | 117 +++++++++++
 tb/tb_dsp_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dsp_sequencer.sv
// Program sequencer for a pipelined DSP core: it walks instruction memory once per
// sample period and then drains the core pipeline. Optional macro DSP_SEQUENCER_OVERRUN_CNT_EN.
module dsp_sequencer #(
  parameter int INSTR_WIDTH     = 26,
  parameter int PROG_ADDR_WIDTH = 10,
  parameter int PIPE_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_start,
  input  logic [PROG_ADDR_WIDTH-1:0] prog_last,
  output logic [PROG_ADDR_WIDTH-1:0] imem_rd_addr,
  input  logic [INSTR_WIDTH-1:0]     imem_rd_data,
  output logic [INSTR_WIDTH-1:0]     instruction,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun
`ifdef DSP_SEQUENCER_OVERRUN_CNT_EN
  ,
  output logic [15:0]                overrun_count
`endif
);

  localparam int CNT_W = $clog2(PIPE_DEPTH + 1);
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(PIPE_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                     state, state_d;
  logic [PROG_ADDR_WIDTH-1:0] pc, pc_d;
  logic [PROG_ADDR_WIDTH-1:0] last_q, last_d;
  logic [CNT_W-1:0]           drain_cnt, drain_d;
  logic                       fetch_valid, fetch_valid_d;
  logic                       overrun_q, overrun_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= '0;
      last_q      <= '0;
      drain_cnt   <= '0;
      fetch_valid <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      last_q      <= last_d;
      drain_cnt   <= drain_d;
      fetch_valid <= fetch_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d       = state;
    pc_d          = pc;
    last_d        = last_q;
    drain_d       = drain_cnt;
    fetch_valid_d = 1'b0;
    busy          = (state != IDLE);
    done          = 1'b0;
    overrun_d     = sample_start && (state != IDLE);
    case (state)
      IDLE: begin
        pc_d    = '0;
        drain_d = '0;
        if (sample_start) begin
          last_d  = prog_last;
          state_d = RUN;
        end
      end
      RUN: begin
        fetch_valid_d = 1'b1;
        // pc holds at last_q on the final fetch so the top address never wraps
        if (pc == last_q) begin
          state_d = DRAIN;
          drain_d = DRAIN_INIT;
        end else begin
          pc_d = pc + PROG_ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          done    = 1'b1;
          state_d = IDLE;
          pc_d    = '0;
        end else begin
          drain_d = drain_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  assign imem_rd_addr = pc;
  assign instruction  = fetch_valid ? imem_rd_data : '0;
  assign overrun      = overrun_q;

`ifdef DSP_SEQUENCER_OVERRUN_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] ovr_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n)       ovr_cnt_q <= '0;
    else if (overrun_q) ovr_cnt_q <= sat_inc(ovr_cnt_q);
  end

  assign overrun_count = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_dsp_sequencer.sv
// Bench for dsp_sequencer: directed scenarios plus random traffic, checked every cycle
// against a pass-window reference model.
module tb_dsp_sequencer;
  localparam int P = 4;

  logic        clk;
  logic        reset_n;
  logic        sample_start;
  logic [9:0]  prog_last;
  logic [9:0]  imem_rd_addr;
  logic [25:0] imem_rd_data;
  logic [25:0] instruction;
  logic        busy;
  logic        done;
  logic        overrun;
`ifdef DSP_SEQUENCER_OVERRUN_CNT_EN
  logic [15:0] overrun_count;
`endif

  dsp_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_start (sample_start),
    .prog_last    (prog_last),
    .imem_rd_addr (imem_rd_addr),
    .imem_rd_data (imem_rd_data),
    .instruction  (instruction),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
`ifdef DSP_SEQUENCER_OVERRUN_CNT_EN
    ,
    .overrun_count(overrun_count)
`endif
  );

  logic [25:0] imem [0:1023];
  always @(posedge clk) imem_rd_data <= imem[imem_rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // reference model: a pass is a window of cycles relative to its accepted start
  bit act      = 1'b0;
  int s        = 0;
  int L        = 0;
  bit ovr_pend = 1'b0;
  int ovr_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit st, input logic [9:0] pl, input bit rn);
    int rel;
    bit eb, ed;
    logic [25:0] ei;
    logic [9:0]  ea;
    sample_start = st;
    prog_last    = pl;
    reset_n      = rn;
    @(negedge clk);
    eb = 1'b0; ed = 1'b0; ei = '0; ea = '0;
    if (act) begin
      rel = cyc - s;
      if (rel >= 1 && rel <= L + 2 + P) begin
        eb = 1'b1;
        ea = (rel - 1 <= L) ? 10'(rel - 1) : 10'(L);
        if (rel >= 2 && rel - 2 <= L) ei = imem[rel - 2];
        ed = (rel == L + 2 + P);
      end
    end
    chk("busy", 32'(busy), 32'(eb));
    chk("done", 32'(done), 32'(ed));
    chk("overrun", 32'(overrun), 32'(ovr_pend));
    chk("instruction", 32'(instruction), 32'(ei));
    chk("imem_rd_addr", 32'(imem_rd_addr), 32'(ea));
`ifdef DSP_SEQUENCER_OVERRUN_CNT_EN
    chk("overrun_count", 32'(overrun_count), 32'(ovr_cnt));
`endif
    if (!rn) begin
      act = 1'b0; ovr_pend = 1'b0; ovr_cnt = 0;
    end else begin
      if (ovr_pend && ovr_cnt < 65535) ovr_cnt++;
      ovr_pend = st && eb;
      if (ed) act = 1'b0;
      if (st && !eb) begin
        act = 1'b1; s = cyc; L = int'(pl);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic [9:0] pl);
    for (int i = 0; i < n; i++) step(1'b0, pl, 1'b1);
  endtask

  initial begin
    sample_start = 1'b0;
    prog_last    = '0;
    reset_n      = 1'b0;
    for (int i = 0; i < 1024; i++) imem[i] = 26'(i + 1) | 26'h0200000;
    imem[0] = 26'h0400001; imem[1] = 26'h0800002;
    imem[2] = 26'h1000003; imem[3] = 26'h1400004;
    @(posedge clk);
    #1;

    // reset state, then a start coincident with reset is ignored
    idle(2, 10'd3);
    step(1'b1, 10'd3, 1'b0);
    idle(3, 10'd3);

    // four-word program, words on cycles 2-5, done on cycle 9
    step(1'b1, 10'd3, 1'b1);
    idle(12, 10'd3);

    // single-instruction pass
    step(1'b1, 10'd0, 1'b1);
    idle(8, 10'd0);

    // overruns at cycle 4 and in the done cycle
    step(1'b1, 10'd3, 1'b0);
    idle(1, 10'd3);
    step(1'b1, 10'd3, 1'b1);
    idle(3, 10'd3);
    step(1'b1, 10'd3, 1'b1);
    idle(4, 10'd3);
    step(1'b1, 10'd3, 1'b1);
    idle(3, 10'd3);
`ifdef DSP_SEQUENCER_OVERRUN_CNT_EN
    chk("overrun_count_two", 32'(overrun_count), 32'd2);
`endif

    // start in the cycle after done is accepted
    step(1'b1, 10'd3, 1'b1);
    idle(9, 10'd3);
    step(1'b1, 10'd3, 1'b1);
    idle(12, 10'd3);

    // reset in the middle of a pass, then a full pass
    step(1'b1, 10'd3, 1'b1);
    idle(2, 10'd3);
    step(1'b0, 10'd3, 1'b0);
    idle(3, 10'd3);
    step(1'b1, 10'd3, 1'b1);
    idle(12, 10'd3);

    // prog_last changes while busy only affect the next pass
    step(1'b1, 10'd3, 1'b1);
    idle(1, 10'd3);
    idle(12, 10'd7);
    step(1'b1, 10'd7, 1'b1);
    idle(14, 10'd7);

    // longest program ends without wrapping the address
    for (int i = 0; i < 1024; i++) imem[i] = 26'($urandom);
    step(1'b1, 10'd1023, 1'b1);
    idle(1035, 10'd5);

    // random traffic with occasional resets
    for (int i = 0; i < 900; i++)
      step($urandom_range(0, 9) == 0, 10'($urandom_range(0, 12)),
           $urandom_range(0, 149) != 0);
    idle(20, 10'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
